muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the execute stage. The main decoder selects it for OP opcodes with funct7 = 0000001, and it holds the pipeline stalled through `busy` until a one-cycle `done` pulse returns the result. It owns one shared XLEN-bit adder/subtractor, which it sequences once per iteration for both shift-add multiplication and restoring division.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- kill  input  1  abort (pipeline flush); returns to IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 value, sampled with start.
- b  input  XLEN  rs2 value, sampled with start.
- busy  output  1  high in CALC and FIX; the stall request to the hazard unit.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result, held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset: state = IDLE; busy, done and counter = 0; result = 0.
- **IDLE/DONE to CALC:** occurs on start & !kill.
  - Latch funct3 and operand magnitudes.
  - Signed operands (a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM) are two's-complement negated when negative. Record sa, sb.
  - Counter = 0.
- **IDLE/DONE to DONE (special case, skips CALC):**
  - DIV/DIVU with b = 0: result = all ones.
  - REM/REMU with b = 0: result = a.
  - DIV with a = 0x8000_0000, b = 0xFFFF_FFFF: result = 0x8000_0000.
  - REM with the same operands: result = 0.
- **DONE with no start:** go to IDLE.
- **CALC, multiply:** 2·XLEN-bit accumulator {hi, lo}, lo initialized to |b|.
  - Each cycle, if lo[0] then hi += |a| (XLEN+1-bit carry), then shift right by 1.
- **CALC, divide:** remainder R (XLEN+1 bits), quotient Q initialized to |a|.
  - Each cycle, shift {R, Q} left 1 and compute R − |b|.
  - If non-negative, R = difference and Q[0] = 1; otherwise R unchanged and Q[0] = 0.
- **CALC to FIX:** when counter = XLEN−1 after its update cycle, i.e. after exactly XLEN iterations.
- **FIX:** apply sign, then load result.
  - Product negated (2·XLEN bits) if sa ^ sb for signed variants.
  - Quotient negated if sa ^ sb (DIV).
  - Remainder negated if sa (REM).
  - MUL takes the low half; MULH/MULHSU/MULHU take the high half. Go to DONE.
- **kill:** from any state, state → IDLE on the next edge, no done, result unchanged. kill beats a simultaneous start.
- start in CALC/FIX is ignored; it is not queued.
- An asynchronous reset asserted mid-operation forces IDLE immediately; the operation is lost.

## Timing
- Let start be accepted at edge E0.
  - Normal path: CALC from E0 through E(XLEN); FIX after E(XLEN); DONE after E(XLEN+1).
  - done is high in cycle XLEN+2 after start: 34 cycles for XLEN = 32.
  - Special case: done is high in the cycle immediately after E0, giving a latency of 1.
- busy is high from the cycle after E0 until DONE is entered, and is low in DONE.
- done is high exactly one cycle. A start in the DONE cycle is accepted, allowing back-to-back operations with no IDLE bubble.
- All outputs are registered or state-decoded; there is no combinational path from the inputs to busy, done or result.

## Test plan
- **MUL and MULH:** MUL a=7, b=−3 gives result 0xFFFF_FFEB and done at cycle 34. MULH 0x8000_0000 × 0x8000_0000 gives 0x4000_0000.
- **Mixed/unsigned high products:** MULHSU a=−1, b=0xFFFF_FFFF gives 0xFFFF_FFFF. MULHU with the same operands gives 0xFFFF_FFFE.
- **Signed divide/remainder:** DIV −7/2 gives 0xFFFF_FFFD. REM −7/2 gives 0xFFFF_FFFF. DIVU 100/7 gives 14, and REMU gives 2.
- **Special cases:**
  - DIV x/0 gives 0xFFFF_FFFF. REMU 5/0 gives 5.
  - DIV 0x8000_0000/−1 gives 0x8000_0000, and REM gives 0.
  - All of these raise done 1 cycle after start with busy never high.
- **Control:**
  - Back-to-back: start asserted in the DONE cycle gives a second done 34 cycles later.
  - start asserted during CALC is ignored.
  - kill at cycle 10 gives IDLE next cycle, no done, and the previous result retained.
- **Reset:** reset asserted mid-CALC clears busy, done and result to 0 asynchronously. After release, a fresh MUL 3×4 gives 12.

Source files
------------

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: one shared adder/subtractor, one shift-add or restoring step per cycle.
// Latency XLEN+2 cycles (1 for divide-by-zero/overflow); busy stalls the pipeline and start is ignored while busy.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        op;
    logic              sa, sb;
    logic [XLEN-1:0]   hi, lo, opnd;
    logic [CW-1:0]     cnt;
    logic              accept, special, a_signed, b_signed, sa_in, sb_in, last;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res, fix_res;
    logic              sub;
    logic [XLEN:0]     add_x;
    logic [XLEN+1:0]   add_y, sum_w;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        accept   = start && !kill && (state == IDLE || state == DONE);
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa_in    = a_signed && a[XLEN-1];
        sb_in    = b_signed && b[XLEN-1];
        abs_a    = sa_in ? -a : a;
        abs_b    = sb_in ? -b : b;
        special  = 1'b0;
        spec_res = '1;
        if (funct3[2] && b == '0) begin
            special  = 1'b1;
            spec_res = funct3[1] ? a : '1;
        end else if (funct3[2] && !funct3[0] && a == MIN_NEG && b == '1) begin
            special  = 1'b1;
            spec_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // Multiply adds |a| into hi; divide subtracts |b| from the shifted {R, Q msb}.
    always_comb begin
        sub   = op[2];
        add_x = sub ? {hi, lo[XLEN-1]} : {1'b0, hi};
        add_y = {2'b00, opnd} ^ {(XLEN+2){sub}};
        sum_w = {1'b0, add_x} + add_y + {{(XLEN+1){1'b0}}, sub};
    end

    always_comb begin
        prod   = {hi, lo};
        prod_s = (sa ^ sb) ? -prod : prod;
        case (op)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = (sa ^ sb) ? -lo : lo;
            default:                fix_res = sa ? -hi : hi;
        endcase
    end

    assign last = (cnt == CW'(XLEN-1));
    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
            CALC:       if (last) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op  <= funct3;
            sa  <= sa_in;
            sb  <= sb_in;
            cnt <= '0;
            hi  <= '0;
            if (funct3[2]) begin
                lo   <= abs_a;
                opnd <= abs_b;
            end else begin
                lo   <= abs_b;
                opnd <= abs_a;
            end
            if (special) result <= spec_res;
        end else if (state == CALC && !kill) begin
            cnt <= cnt + CW'(1);
            if (op[2]) begin
                lo <= {lo[XLEN-2:0], ~sum_w[XLEN+1]};
                if (!sum_w[XLEN+1]) hi <= sum_w[XLEN-1:0];
                else                hi <= {hi[XLEN-2:0], lo[XLEN-1]};
            end else if (lo[0]) begin
                {hi, lo} <= {sum_w[XLEN:0], lo[XLEN-1:1]};
            end else begin
                {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
            end
        end else if (state == FIX && !kill) begin
            result <= fix_res;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, latency, busy, kill and reset behaviour.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Launch one op; optionally pulse a stray start at cycle poke. Returns at the done-cycle negedge.
    task automatic run_op(input logic wait_first, input logic [2:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input int poke, input logic [31:0] expv,
                          input int exp_lat, input string tag);
        int   lat;
        logic bs;
        if (wait_first) @(negedge clk);
        start = 1'b1; funct3 = f; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bs = 1'b0;
        while (!done && lat < 200) begin
            bs = bs | busy;
            if (lat == poke) begin
                start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check($sformatf("%s done", tag), {31'b0, done}, 32'd1);
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s result", tag), result, expv);
        check($sformatf("%s busy_seen", tag), {31'b0, bs}, {31'b0, exp_lat > 1});
    endtask

    initial begin
        int   lat;
        logic seen;

        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b1;

        run_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 34, "mul 7*-3");
        @(negedge clk);
        check("done one cycle", {31'b0, done}, 32'd0);
        run_op(1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 34, "mulh min*min");
        run_op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 34, "mulhsu -1*max");
        run_op(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 34, "mulhu max*max");
        run_op(1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 34, "div -7/2");
        run_op(1'b1, 3'b110, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 34, "rem -7/2");
        run_op(1'b1, 3'b101, 32'd100, 32'd7, 0, 32'd14, 34, "divu 100/7");
        run_op(1'b1, 3'b111, 32'd100, 32'd7, 0, 32'd2, 34, "remu 100/7");

        run_op(1'b1, 3'b100, 32'd123, 32'd0, 0, 32'hFFFF_FFFF, 1, "div x/0");
        run_op(1'b1, 3'b111, 32'd5, 32'd0, 0, 32'd5, 1, "remu 5/0");
        run_op(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, "div ovf");
        run_op(1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 1, "rem ovf");

        run_op(1'b1, 3'b000, 32'd3, 32'd5, 0, 32'd15, 34, "b2b first");
        run_op(1'b0, 3'b101, 32'd100, 32'd7, 0, 32'd14, 34, "b2b second");

        run_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5, 32'hFFFF_FFEB, 34, "start in calc");

        // kill during CALC: IDLE on the next edge, no done, result retained
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", {31'b0, busy}, 32'd0);
        check("kill done", {31'b0, done}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | done | busy;
            @(negedge clk);
        end
        check("kill no done later", {31'b0, seen}, 32'd0);
        check("kill result kept", result, 32'hFFFF_FFEB);

        // asynchronous reset mid-CALC
        start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b1, 3'b000, 32'd3, 32'd4, 0, 32'd12, 34, "mul after reset");

        lat = 0;
        while (done && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check("idle after done", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
